// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt/ERET detection with registered pipeline flush and CP0 update strobes.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_bd_i,
  input  logic        exc_syscall_i,
  input  logic        exc_inv_i,
  input  logic        exc_trap_i,
  input  logic        exc_ov_i,
  input  logic        exc_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] excepttype_o,
  output logic        cp0_we_o,
  output logic [31:0] cp0_epc_o,
  output logic [4:0]  cp0_exccode_o,
  output logic        cp0_bd_o,
  output logic        cp0_exl_set_o,
  output logic        cp0_exl_clr_o,
  output logic        busy_o,
  output logic [15:0] exc_cnt_o
);
  typedef enum logic [1:0] {IDLE, FLUSH, HOLD} state_t;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] hold_cnt;
  logic [31:0] status, cause, epc, code;
  logic irq, det, eret_sel, unused_ok;
  // Forward an in-flight write-back CP0 write so detection sees the newest values
  always_comb begin
    status = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_data_i : cp0_status_i;
    cause = cp0_cause_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) begin
      cause[9:8] = wb_cp0_data_i[9:8];
      cause[23:22] = wb_cp0_data_i[23:22];
    end
    epc = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_data_i : cp0_epc_i;
    irq = status[0] && !status[1] && |(cause[15:8] & status[15:8]);
    code = irq ? 32'h01 : exc_syscall_i ? 32'h08 : exc_inv_i ? 32'h0a :
           exc_trap_i ? 32'h0d : exc_ov_i ? 32'h0c : exc_eret_i ? 32'h0e : 32'h0;
    det = state == IDLE && mem_valid_i && code != 32'h0;
    eret_sel = code == 32'h0e;
    state_n = state == IDLE ? (det ? FLUSH : IDLE) :
              state == FLUSH ? HOLD : (hold_cnt == HOLD_LAST ? IDLE : HOLD);
    unused_ok = ^{status, cause};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      hold_cnt <= state == HOLD ? hold_cnt + 4'd1 : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_o <= 1'b0;
      new_pc_o <= '0;
      excepttype_o <= '0;
      cp0_we_o <= 1'b0;
      cp0_epc_o <= '0;
      cp0_exccode_o <= '0;
      cp0_bd_o <= 1'b0;
      cp0_exl_set_o <= 1'b0;
      cp0_exl_clr_o <= 1'b0;
      exc_cnt_o <= '0;
    end else begin
      flush_o <= det;
      cp0_we_o <= det && !eret_sel && !status[1];
      cp0_exl_set_o <= det && !eret_sel;
      cp0_exl_clr_o <= det && eret_sel;
      if (det) begin
        new_pc_o <= eret_sel ? epc : EXC_VECTOR;
        excepttype_o <= code;
        cp0_epc_o <= mem_bd_i ? mem_pc_i - 32'd4 : mem_pc_i;
        cp0_exccode_o <= code[4:0];
        cp0_bd_o <= mem_bd_i;
        if (exc_cnt_o != 16'hFFFF) exc_cnt_o <= exc_cnt_o + 16'd1;
      end
    end
  end
  assign busy_o = state != IDLE;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed scoreboard bench for exc_ctrl; expected flush payloads are queued at drive time and checked when flush_o fires.
module tb_exc_ctrl;
  logic clk = 0, rst = 1;
  logic mem_valid_i = 0, mem_bd_i = 0;
  logic [31:0] mem_pc_i = 0;
  logic exc_syscall_i = 0, exc_inv_i = 0, exc_trap_i = 0, exc_ov_i = 0, exc_eret_i = 0;
  logic [31:0] cp0_status_i = 0, cp0_cause_i = 0, cp0_epc_i = 0;
  logic wb_cp0_we_i = 0;
  logic [4:0] wb_cp0_waddr_i = 0;
  logic [31:0] wb_cp0_data_i = 0;
  logic flush_o, cp0_we_o, cp0_bd_o, cp0_exl_set_o, cp0_exl_clr_o, busy_o;
  logic [31:0] new_pc_o, excepttype_o, cp0_epc_o;
  logic [4:0] cp0_exccode_o;
  logic [15:0] exc_cnt_o;
  typedef struct {
    logic [31:0] pc, typ, epc;
    logic we, set, clr, bd;
  } exp_t;
  exp_t sb[$];
  int checks = 0, passes = 0, pulses = 0, p0;
  logic [15:0] cnt_exp = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_bd_i(mem_bd_i),
    .exc_syscall_i(exc_syscall_i), .exc_inv_i(exc_inv_i), .exc_trap_i(exc_trap_i),
    .exc_ov_i(exc_ov_i), .exc_eret_i(exc_eret_i), .cp0_status_i(cp0_status_i),
    .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i),
    .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i), .flush_o(flush_o),
    .new_pc_o(new_pc_o), .excepttype_o(excepttype_o), .cp0_we_o(cp0_we_o),
    .cp0_epc_o(cp0_epc_o), .cp0_exccode_o(cp0_exccode_o), .cp0_bd_o(cp0_bd_o),
    .cp0_exl_set_o(cp0_exl_set_o), .cp0_exl_clr_o(cp0_exl_clr_o), .busy_o(busy_o),
    .exc_cnt_o(exc_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] typ, input logic [31:0] epc,
                      input logic we, input logic set, input logic clr, input logic bd);
    exp_t e;
    e.pc = pc; e.typ = typ; e.epc = epc; e.we = we; e.set = set; e.clr = clr; e.bd = bd;
    sb.push_back(e);
    if (cnt_exp != 16'hFFFF) cnt_exp++;
  endtask

  task automatic idle_inputs();
    mem_valid_i = 0; mem_bd_i = 0; mem_pc_i = 0;
    {exc_syscall_i, exc_inv_i, exc_trap_i, exc_ov_i, exc_eret_i} = '0;
    cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_data_i = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (flush_o) begin
      exp_t e;
      pulses++;
      if (sb.size() == 0) chk("unexpected_flush", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("new_pc", new_pc_o, e.pc);
        chk("excepttype", excepttype_o, e.typ);
        chk("exccode", {27'd0, cp0_exccode_o}, {27'd0, e.typ[4:0]});
        chk("epc", cp0_epc_o, e.epc);
        chk("cp0_we", {31'd0, cp0_we_o}, {31'd0, e.we});
        chk("exl_set", {31'd0, cp0_exl_set_o}, {31'd0, e.set});
        chk("exl_clr", {31'd0, cp0_exl_clr_o}, {31'd0, e.clr});
        chk("bd", {31'd0, cp0_bd_o}, {31'd0, e.bd});
      end
    end
  end

  initial begin
    tick(2);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_cnt", {16'd0, exc_cnt_o}, 32'd0);
    chk("rst_new_pc", new_pc_o, 32'd0);
    chk("rst_epc", cp0_epc_o, 32'd0);
    rst = 0;
    tick(1);
    // basic syscall: one flush pulse, two busy cycles
    mem_valid_i = 1; exc_syscall_i = 1; mem_pc_i = 32'h100; cp0_status_i = 32'h1;
    push(32'h20, 32'h08, 32'h100, 1, 1, 0, 0);
    tick(1); idle_inputs();
    chk("busy_flush", {31'd0, busy_o}, 32'd1);
    tick(1);
    chk("busy_hold", {31'd0, busy_o}, 32'd1);
    chk("flush_gone", {31'd0, flush_o}, 32'd0);
    chk("we_gone", {31'd0, cp0_we_o}, 32'd0);
    chk("new_pc_held", new_pc_o, 32'h20);
    tick(1);
    chk("busy_idle", {31'd0, busy_o}, 32'd0);
    chk("cnt1", {16'd0, exc_cnt_o}, {16'd0, cnt_exp});
    // overflow in delay slot
    mem_valid_i = 1; exc_ov_i = 1; mem_bd_i = 1; mem_pc_i = 32'h204;
    push(32'h20, 32'h0c, 32'h200, 1, 1, 0, 1);
    tick(1); idle_inputs(); tick(2);
    // interrupt beats concurrent syscall
    mem_valid_i = 1; exc_syscall_i = 1; cp0_status_i = 32'h8001; cp0_cause_i = 32'h8000; mem_pc_i = 32'h40;
    push(32'h20, 32'h01, 32'h40, 1, 1, 0, 0);
    tick(1); idle_inputs(); tick(2);
    // EXL already set: interrupt masked, EPC not rewritten
    mem_valid_i = 1; exc_syscall_i = 1; cp0_status_i = 32'h8003; cp0_cause_i = 32'h8000; mem_pc_i = 32'h44;
    push(32'h20, 32'h08, 32'h44, 0, 1, 0, 0);
    tick(1); idle_inputs(); tick(2);
    // ERET with forwarded EPC write
    mem_valid_i = 1; exc_eret_i = 1; cp0_epc_i = 32'h300; mem_pc_i = 32'h500;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h400;
    push(32'h400, 32'h0e, 32'h500, 0, 0, 1, 0);
    tick(1); idle_inputs(); tick(2);
    // interrupt enabled only through forwarded Status write
    mem_valid_i = 1; cp0_cause_i = 32'h0400; mem_pc_i = 32'h60;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0401;
    push(32'h20, 32'h01, 32'h60, 1, 1, 0, 0);
    tick(1); idle_inputs(); tick(2);
    // trap vs overflow priority, delay slot at address 0 wraps
    mem_valid_i = 1; exc_trap_i = 1; exc_ov_i = 1; mem_bd_i = 1; mem_pc_i = 32'h0;
    push(32'h20, 32'h0d, 32'hFFFF_FFFC, 1, 1, 0, 1);
    tick(1); idle_inputs(); tick(2);
    // invalid instruction beats trap
    mem_valid_i = 1; exc_inv_i = 1; exc_trap_i = 1; mem_pc_i = 32'h80;
    push(32'h20, 32'h0a, 32'h80, 1, 1, 0, 0);
    tick(1); idle_inputs(); tick(2);
    // flags without mem_valid are ignored
    p0 = pulses;
    exc_syscall_i = 1; exc_ov_i = 1;
    tick(3); idle_inputs();
    chk("no_valid_no_flush", pulses - p0, 0);
    // syscall held two cycles: second is swallowed by FLUSH
    p0 = pulses;
    mem_valid_i = 1; exc_syscall_i = 1; mem_pc_i = 32'h120;
    push(32'h20, 32'h08, 32'h120, 1, 1, 0, 0);
    tick(2); idle_inputs(); tick(2);
    chk("one_pulse", pulses - p0, 1);
    chk("cnt_after_dup", {16'd0, exc_cnt_o}, {16'd0, cnt_exp});
    // reset in the middle of FLUSH
    mem_valid_i = 1; exc_syscall_i = 1; mem_pc_i = 32'h140;
    push(32'h20, 32'h08, 32'h140, 1, 1, 0, 0);
    tick(1); idle_inputs(); rst = 1;
    tick(1);
    chk("rst_mid_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mid_cnt", {16'd0, exc_cnt_o}, 32'd0);
    rst = 0;
    tick(2);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0020, general exception handler address.
REQ-002 Parameter HOLD_CYCLES, default 1, post-flush cycles during which new exceptions are ignored (range 1-15).
REQ-003 Clock clk, input, 1, rising-edge; reset rst, input, 1, synchronous, active-high.
REQ-004 mem_valid_i input 1, MEM-stage instruction valid; mem_pc_i input 32, its address; mem_bd_i input 1, instruction is in a delay slot.
REQ-005 exc_syscall_i, exc_inv_i, exc_trap_i, exc_ov_i, exc_eret_i inputs, 1 each: syscall, reserved instruction, trap, overflow, ERET flags from MEM.
REQ-006 cp0_status_i, cp0_cause_i, cp0_epc_i inputs, 32 each: current CP0 Status/Cause/EPC.
REQ-007 wb_cp0_we_i input 1, wb_cp0_waddr_i input 5, wb_cp0_data_i input 32: in-flight CP0 write from write-back.
REQ-008 flush_o output 1, pipeline flush pulse; new_pc_o output 32, redirect target; excepttype_o output 32, exception code of taken event.
REQ-009 cp0_we_o output 1, cp0_epc_o output 32, cp0_exccode_o output 5, cp0_bd_o output 1, cp0_exl_set_o output 1, cp0_exl_clr_o output 1: CP0 update strobe and fields.
REQ-010 busy_o output 1, high while not IDLE; exc_cnt_o output 16, count of taken events.

Function
REQ-011 Effective Status = wb_cp0_data_i when wb_cp0_we_i and waddr==12, else cp0_status_i.
REQ-012 Effective Cause = cp0_cause_i with bits [9:8],[22],[23] replaced by wb_cp0_data_i when wb_cp0_we_i and waddr==13.
REQ-013 Effective EPC = wb_cp0_data_i when wb_cp0_we_i and waddr==14, else cp0_epc_i.
REQ-014 Interrupt pending = Status[0]==1, Status[1]==0, and (Cause[15:8] & Status[15:8]) != 0 (effective values).
REQ-015 Event detected only in IDLE with mem_valid_i==1; priority, highest first: interrupt 0x01, syscall 0x08, invalid 0x0a, trap 0x0d, overflow 0x0c, ERET 0x0e.
REQ-016 States IDLE, FLUSH, HOLD; IDLE->FLUSH on detected event; FLUSH->HOLD always; HOLD->IDLE after HOLD_CYCLES cycles.
REQ-017 Detection at edge N registers all outputs; flush_o, cp0 strobes, and valid new_pc_o/excepttype_o are driven during cycle N+1 (FLUSH), one cycle only.
REQ-018 Non-ERET event: new_pc_o=EXC_VECTOR, cp0_we_o=1, cp0_exl_set_o=1, cp0_exccode_o=excepttype[4:0] >> 0 truncated code, cp0_bd_o=mem_bd_i.
REQ-019 cp0_epc_o = mem_pc_i-4 when mem_bd_i==1, else mem_pc_i; 32-bit wrap-around subtraction.
REQ-020 ERET: new_pc_o=effective EPC, cp0_exl_clr_o=1, cp0_we_o=0, cp0_exl_set_o=0.
REQ-021 Exception with Status[1]==1 (EXL already set): still flush and redirect; cp0_we_o=0 (EPC not overwritten).
REQ-022 Outside FLUSH: flush_o, cp0_we_o, cp0_exl_set_o, cp0_exl_clr_o =0; new_pc_o, excepttype_o hold last value.
REQ-023 All exception flags and mem_valid_i ignored in FLUSH and HOLD.
REQ-024 exc_cnt_o increments on every IDLE->FLUSH transition, saturating at 16'hFFFF.
REQ-025 Multiple simultaneous flags: only highest-priority code reported; one FLUSH cycle.

Reset
REQ-026 rst at any edge, including mid-FLUSH/HOLD: state IDLE; all 1-bit outputs 0; new_pc_o, excepttype_o, cp0_epc_o 0; cp0_exccode_o 0; exc_cnt_o 0; rst has priority over detection.

Verification
REQ-027 Syscall, mem_pc_i=32'h100, mem_bd_i=0, Status=32'h1 -> next cycle flush_o=1, new_pc_o=32'h20, excepttype_o=8, cp0_epc_o=32'h100, cp0_exl_set_o=1; busy_o 2 cycles.
REQ-028 Overflow in delay slot, mem_pc_i=32'h204 -> cp0_epc_o=32'h200, cp0_bd_o=1, excepttype_o=32'h0c.
REQ-029 Status=32'h0000_8001, Cause[15]=1, concurrent syscall -> excepttype_o=1 (interrupt wins); same with Status[1]=1 -> excepttype_o=8, cp0_we_o=0.
REQ-030 ERET with cp0_epc_i=32'h300 and same-cycle WB write addr 14 data 32'h400 -> new_pc_o=32'h400, cp0_exl_clr_o=1, cp0_we_o=0.
REQ-031 Syscall asserted on two consecutive cycles -> exactly one flush_o pulse, exc_cnt_o=1.
REQ-032 rst asserted during FLUSH -> following cycle flush_o=0, busy_o=0, exc_cnt_o=0.
